div_exec: RTL and testbench

DIV_EXEC -- requirements
Module: div_exec

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_seq.sv | 65 ++++++
 rtl/div_exec.sv | 163 ++++++++++++++++
 tb/tb_div_exec.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the divide execution block and the
// instruction memory stage that feeds it.
//   OP_*    : 3-bit opcode constants carried on func
//   state_t : execution FSM state (IDLE accepts instructions, RUN divides)
package div_pkg;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_LD1 = 3'd1;
  localparam logic [2:0] OP_LD2 = 3'd2;
  localparam logic [2:0] OP_LD3 = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_RES = 3'd5;
  localparam logic [2:0] OP_DIS = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/div_seq.sv
// div_seq -- repeated-subtraction divider datapath.
//   clk, rst         : clock, async active-high reset
//   clr              : zero quo/rem
//   start            : rem <= dividend, quo <= 0 (begin a divide)
//   zload            : quo <= all-ones, rem <= dividend (divide-by-zero result)
//   step             : rem <= rem - divisor, quo <= quo + 1
//   dividend/divisor : operand registers from the decode stage
//   quo, rem         : running quotient / remainder
//   ge               : rem >= divisor (another subtraction is due)
module div_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic         zload,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         ge
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;

  // Controls are mutually exclusive by construction in the decoder;
  // the priority order here only makes that explicit.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    if (clr) begin
      quo_d = '0;
      rem_d = '0;
    end else if (start) begin
      quo_d = '0;
      rem_d = dividend;
    end else if (zload) begin
      quo_d = '1;
      rem_d = dividend;
    end else if (step) begin
      quo_d = quo_q + ONE;
      rem_d = rem_q - divisor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;
  assign ge  = (rem_q >= divisor);

endmodule

// File: rtl/div_exec.sv
// div_exec -- instruction decode, operand/result registers and handshake
// around the div_seq repeated-subtraction divider.
//   clk, rst          : clock, async active-high reset
//   func, value       : opcode and immediate operand
//   instr_valid/ready : accept handshake; ready only in IDLE
//   result_q/result_r : quotient/remainder latched by RES
//   disp, disp_strobe : display register and its one-cycle update pulse
//   div_err           : sticky divide-by-zero flag (DIV_ZERO_ERR_EN only)
// Build option: define DIV_ZERO_ERR_EN to flag divide-by-zero instead of
// producing the all-ones quotient.
module div_exec
  import div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   func,
  input  logic [W-1:0] value,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [W-1:0] result_q,
  output logic [W-1:0] result_r,
  output logic [W-1:0] disp,
  output logic         disp_strobe
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic         div_err
`endif
);

  state_t       state_q, state_d;
  logic [W-1:0] r1_q, r1_d, r2_q, r2_d;
  logic         sel_q, sel_d;
  logic [W-1:0] rq_q, rq_d, rr_q, rr_d;
  logic [W-1:0] disp_q, disp_d;
  logic         strobe_q, strobe_d;
`ifdef DIV_ZERO_ERR_EN
  logic         err_q, err_d;
`endif

  logic         seq_clr, seq_start, seq_zload, seq_step, seq_ge;
  logic [W-1:0] quo, rem;

  always_comb begin
    state_d   = state_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    sel_d     = sel_q;
    rq_d      = rq_q;
    rr_d      = rr_q;
    disp_d    = disp_q;
    strobe_d  = 1'b0;
    seq_clr   = 1'b0;
    seq_start = 1'b0;
    seq_zload = 1'b0;
`ifdef DIV_ZERO_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          case (func)
            OP_CLR: begin
              r1_d    = '0;
              r2_d    = '0;
              sel_d   = 1'b0;
              rq_d    = '0;
              rr_d    = '0;
              seq_clr = 1'b1;
`ifdef DIV_ZERO_ERR_EN
              err_d   = 1'b0;
`endif
            end
            OP_LD1: r1_d  = value;
            OP_LD2: r2_d  = value;
            OP_LD3: sel_d = value[0];
            OP_DIV: begin
              if (r2_q != '0) begin
                seq_start = 1'b1;
                state_d   = RUN;
              end else begin
`ifdef DIV_ZERO_ERR_EN
                err_d     = 1'b1;
`else
                seq_zload = 1'b1;
`endif
              end
            end
            OP_RES: begin
              rq_d = quo;
              rr_d = rem;
            end
            OP_DIS: begin
              disp_d   = sel_q ? rr_q : rq_q;
              strobe_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        // Final RUN cycle is the one where no subtraction fits.
        if (!seq_ge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign seq_step = (state_q == RUN) && seq_ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r1_q     <= '0;
      r2_q     <= '0;
      sel_q    <= 1'b0;
      rq_q     <= '0;
      rr_q     <= '0;
      disp_q   <= '0;
      strobe_q <= 1'b0;
`ifdef DIV_ZERO_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      sel_q    <= sel_d;
      rq_q     <= rq_d;
      rr_q     <= rr_d;
      disp_q   <= disp_d;
      strobe_q <= strobe_d;
`ifdef DIV_ZERO_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  div_seq #(.W(W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (seq_clr),
    .start    (seq_start),
    .zload    (seq_zload),
    .step     (seq_step),
    .dividend (r1_q),
    .divisor  (r2_q),
    .quo      (quo),
    .rem      (rem),
    .ge       (seq_ge)
  );

  assign instr_ready = (state_q == IDLE);
  assign result_q    = rq_q;
  assign result_r    = rr_q;
  assign disp        = disp_q;
  assign disp_strobe = strobe_q;
`ifdef DIV_ZERO_ERR_EN
  assign div_err     = err_q;
`endif

endmodule

// File: tb/tb_div_exec.sv
// tb_div_exec -- self-checking bench for div_exec (W=4): a directed table
// of instructions with constant expectations, hand-written stall and
// mid-divide reset sequences, and random instructions checked against an
// arithmetic reference model. Honours DIV_ZERO_ERR_EN like the design.
module tb_div_exec;
  import div_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   func;
  logic [W-1:0] value;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] result_q, result_r, disp;
  logic         disp_strobe;
`ifdef DIV_ZERO_ERR_EN
  logic         div_err;
`endif

  div_exec #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .func        (func),
    .value       (value),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .result_q    (result_q),
    .result_r    (result_r),
    .disp        (disp),
    .disp_strobe (disp_strobe)
`ifdef DIV_ZERO_ERR_EN
    ,
    .div_err     (div_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_r1, m_r2, m_sel, m_quo, m_rem, m_rq, m_rr, m_disp, m_err;

  typedef struct {
    logic [2:0] op;
    logic [3:0] val;
    int rq, rr, dsp, busy, err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_r1 = 0; m_r2 = 0; m_sel = 0; m_quo = 0; m_rem = 0;
    m_rq = 0; m_rr = 0; m_disp = 0; m_err = 0;
  endfunction

  // Applies one accepted instruction; returns the expected busy cycles.
  function automatic int model_apply(input logic [2:0] op, input logic [3:0] v);
    int eb = 0;
    case (op)
      OP_CLR: begin
        m_r1 = 0; m_r2 = 0; m_sel = 0; m_quo = 0; m_rem = 0;
        m_rq = 0; m_rr = 0; m_err = 0;
      end
      OP_LD1: m_r1 = v;
      OP_LD2: m_r2 = v;
      OP_LD3: m_sel = v % 2;
      OP_DIV: begin
        if (m_r2 != 0) begin
          m_quo = m_r1 / m_r2;
          m_rem = m_r1 % m_r2;
          eb = m_quo + 1;
        end else begin
`ifdef DIV_ZERO_ERR_EN
          m_err = 1;
`else
          m_quo = (1 << W) - 1;
          m_rem = m_r1;
`endif
        end
      end
      OP_RES: begin m_rq = m_quo; m_rr = m_rem; end
      OP_DIS: m_disp = m_sel ? m_rr : m_rq;
      default: ;
    endcase
    return eb;
  endfunction

  // Presents an instruction and holds it until accepted; waited = number
  // of cycles it sat unaccepted.
  task automatic issue(input logic [2:0] op, input logic [3:0] v, output int waited);
    @(negedge clk);
    func = op; value = v; instr_valid = 1'b1;
    waited = 0;
    while (instr_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 100 cycles");
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_result_q"}, result_q, m_rq);
    chk({tag, "_result_r"}, result_r, m_rr);
    chk({tag, "_disp"}, disp, m_disp);
`ifdef DIV_ZERO_ERR_EN
    chk({tag, "_div_err"}, div_err, m_err);
`endif
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] v, output int busy);
    int w, eb;
    issue(op, v, w);
    eb = model_apply(op, v);
    @(negedge clk);
    chk("strobe_after_accept", disp_strobe, (op == OP_DIS));
    busy = 0;
    while (instr_ready !== 1'b1 && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", busy, eb);
    @(negedge clk);
    chk("strobe_one_cycle", disp_strobe, 0);
    chk_outputs("op");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int b, w, zq, zr, ze;
    rst = 1'b1; instr_valid = 1'b0; func = '0; value = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_strobe", disp_strobe, 0);
    chk_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);

    // divide-by-zero result after 7/3 was RES'd (quo 2, rem 1)
`ifdef DIV_ZERO_ERR_EN
    zq = 2; zr = 1; ze = 1;
`else
    zq = 15; zr = 7; ze = 0;
`endif
    //            op      val   rq  rr  dsp busy err
    tbl.push_back('{OP_LD1, 4'd4,  0,  0,  0,  0,  0});
    tbl.push_back('{OP_LD2, 4'd2,  0,  0,  0,  0,  0});
    tbl.push_back('{OP_DIV, 4'd0,  0,  0,  0,  3,  0});
    tbl.push_back('{OP_RES, 4'd0,  2,  0,  0,  0,  0});
    tbl.push_back('{OP_DIS, 4'd0,  2,  0,  2,  0,  0});
    tbl.push_back('{OP_LD1, 4'd15, 2,  0,  2,  0,  0});
    tbl.push_back('{OP_LD2, 4'd1,  2,  0,  2,  0,  0});
    tbl.push_back('{OP_DIV, 4'd0,  2,  0,  2, 16,  0});
    tbl.push_back('{OP_RES, 4'd0, 15,  0,  2,  0,  0});
    tbl.push_back('{OP_LD1, 4'd7, 15,  0,  2,  0,  0});
    tbl.push_back('{OP_LD2, 4'd3, 15,  0,  2,  0,  0});
    tbl.push_back('{OP_DIV, 4'd0, 15,  0,  2,  3,  0});
    tbl.push_back('{OP_RES, 4'd0,  2,  1,  2,  0,  0});
    tbl.push_back('{OP_LD3, 4'd1,  2,  1,  2,  0,  0});
    tbl.push_back('{OP_DIS, 4'd0,  2,  1,  1,  0,  0});
    tbl.push_back('{OP_LD2, 4'd0,  2,  1,  1,  0,  0});
    tbl.push_back('{OP_DIV, 4'd0,  2,  1,  1,  0, ze});
    tbl.push_back('{OP_RES, 4'd0, zq, zr,  1,  0, ze});
    tbl.push_back('{OP_NOP, 4'd5, zq, zr,  1,  0, ze});
    tbl.push_back('{OP_CLR, 4'd0,  0,  0,  1,  0,  0});
    tbl.push_back('{OP_RES, 4'd0,  0,  0,  1,  0,  0});
    tbl.push_back('{OP_DIS, 4'd0,  0,  0,  0,  0,  0});

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].op, tbl[i].val, b);
      chk("tbl_busy", b, tbl[i].busy);
      chk("tbl_result_q", result_q, tbl[i].rq);
      chk("tbl_result_r", result_r, tbl[i].rr);
      chk("tbl_disp", disp, tbl[i].dsp);
`ifdef DIV_ZERO_ERR_EN
      chk("tbl_div_err", div_err, tbl[i].err);
`endif
    end

    // LD1 held valid while a 5/1 divide runs: stalls for the 6 RUN cycles,
    // and the divide still uses the old R1.
    do_op(OP_LD1, 4'd5, b);
    do_op(OP_LD2, 4'd1, b);
    issue(OP_DIV, 4'd0, w);
    void'(model_apply(OP_DIV, 4'd0));
    issue(OP_LD1, 4'd9, w);
    void'(model_apply(OP_LD1, 4'd9));
    chk("stall_cycles", w, 6);
    do_op(OP_RES, 4'd0, b);
    chk("stall_old_r1_q", result_q, 5);
    do_op(OP_DIV, 4'd0, b);
    chk("stall_new_r1_busy", b, 10);
    do_op(OP_RES, 4'd0, b);
    chk("stall_new_r1_q", result_q, 9);

    // Reset four cycles into a 12/1 divide.
    do_op(OP_LD1, 4'd12, b);
    do_op(OP_DIS, 4'd0, b);
    chk("pre_rst_disp", disp, 9);
    issue(OP_DIV, 4'd0, w);
    repeat (4) @(negedge clk);
    chk("mid_div_ready", instr_ready, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("abort_ready", instr_ready, 1);
    chk("abort_strobe", disp_strobe, 0);
    chk_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", instr_ready, 1);
    do_op(OP_RES, 4'd0, b);
    chk("abort_res_q", result_q, 0);
    chk("abort_res_r", result_r, 0);

    // Random instructions against the model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [3:0] v;
      op = 3'($urandom_range(0, 7));
      if (op == OP_CLR && $urandom_range(0, 3) != 0) op = OP_DIV;
      v = 4'($urandom_range(0, 15));
      do_op(op, v, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
